// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types for the fetch-stage sequencing controller.
// The request enum is ordered by priority, highest first after REQ_NONE.
package fetch_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int MC_W_DEF   = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  // Request selected in RUN; declaration order is the service priority.
  typedef enum logic [2:0] {
    REQ_NONE = 3'd0,
    REQ_BR   = 3'd1,
    REQ_JMP  = 3'd2,
    REQ_LD   = 3'd3,
    REQ_MC   = 3'd4
  } fetch_req_e;

  // Resolve simultaneous requests: branch > jump > load-use > multi-cycle.
  function automatic fetch_req_e pick_req(input logic br, input logic jmp,
                                          input logic ld, input logic mc_nz);
    if (br)         return REQ_BR;
    else if (jmp)   return REQ_JMP;
    else if (ld)    return REQ_LD;
    else if (mc_nz) return REQ_MC;
    else            return REQ_NONE;
  endfunction

endpackage

// File: rtl/fetch_ctrl_stall_timer.sv
// stall_timer: loadable down-counter that times a multi-cycle stall.
// On load the count becomes len-1 (the load cycle is itself a stall cycle);
// done flags the final stall cycle. The counter stops at 0 and never wraps.
module stall_timer #(
  parameter int MC_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            dec,
  input  logic [MC_W-1:0] len,
  output logic            done
);

  localparam logic [MC_W-1:0] ONE = MC_W'(1);

  logic [MC_W-1:0] count;

  // Load, then count down once per held cycle; sync active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= len - ONE;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign done = load ? (len == ONE) : (count == ONE);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: merges redirect and stall requests into PC-block controls.
// Outputs are Mealy (registered state + current inputs), forced to 0 in reset.
// Handshake: requests are level inputs sampled every cycle with no ready;
// upstream holds them stable while busy is high and the FSM ignores them in HOLD.
// Optional: define FETCH_PERF_CNT_EN to add saturating stall_cnt/redir_cnt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int MC_W   = MC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jmp_req,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              ld_use,
  input  logic              mc_start,
  input  logic [MC_W-1:0]   mc_cycles,
  output logic              stall,
  output logic              stall_pm,
  output logic              pc_mux_sel,
  output logic [ADDR_W-1:0] jmp_loc,
  output logic              flush_id,
  output logic              bubble_ex,
  output logic              busy,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       redir_cnt,
`endif
  output fetch_state_e      state_dbg
);

  fetch_state_e state, next_state;
  fetch_req_e   req;
  logic         tmr_load, tmr_done;

  stall_timer #(.MC_W(MC_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .dec   (state == HOLD),
    .len   (mc_cycles),
    .done  (tmr_done)
  );

  // Output decode and next-state selection for the current cycle.
  always_comb begin
    stall      = 1'b0;
    stall_pm   = 1'b0;
    pc_mux_sel = 1'b0;
    jmp_loc    = '0;
    flush_id   = 1'b0;
    bubble_ex  = 1'b0;
    busy       = 1'b0;
    tmr_load   = 1'b0;
    next_state = state;
    req        = pick_req(br_taken, jmp_req, ld_use,
                          mc_start && (mc_cycles != '0));
    if (reset) begin
      busy = (state != RUN);
      case (state)
        RUN: begin
          case (req)
            REQ_BR: begin
              pc_mux_sel = 1'b1;
              jmp_loc    = br_target;
              flush_id   = 1'b1;
              next_state = FLUSH;
            end
            REQ_JMP: begin
              pc_mux_sel = 1'b1;
              jmp_loc    = jmp_target;
              next_state = FLUSH;
            end
            REQ_LD: begin
              stall     = 1'b1;
              stall_pm  = 1'b1;
              bubble_ex = 1'b1;
            end
            REQ_MC: begin
              stall      = 1'b1;
              stall_pm   = 1'b1;
              tmr_load   = 1'b1;
              next_state = tmr_done ? RUN : HOLD;
            end
            default: ;
          endcase
        end
        HOLD: begin
          stall    = 1'b1;
          stall_pm = 1'b1;
          if (tmr_done) next_state = RUN;
        end
        FLUSH: begin
          flush_id = 1'b1;
          if (br_taken) begin
            pc_mux_sel = 1'b1;
            jmp_loc    = br_target;
            next_state = FLUSH;
          end else begin
            next_state = RUN;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  // State register; sync active-low reset returns to RUN.
  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else        state <= next_state;
  end

  assign state_dbg = state;

`ifdef FETCH_PERF_CNT_EN
  // Saturating event counters for stall and redirect cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != 16'hFFFF))      stall_cnt <= stall_cnt + 16'd1;
      if (pc_mux_sel && (redir_cnt != 16'hFFFF)) redir_cnt <= redir_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl with an independent
// cycle model; expected output vectors are queued per driven cycle.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int OUT_W = 14;

  logic       clk, reset;
  logic       jmp_req, br_taken, ld_use, mc_start;
  logic [7:0] jmp_target, br_target;
  logic [3:0] mc_cycles;
  logic       stall, stall_pm, pc_mux_sel, flush_id, bubble_ex, busy;
  logic [7:0] jmp_loc;
  fetch_state_e state_dbg;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt, redir_cnt;
  logic [15:0] m_stall_cnt, m_redir_cnt;
`endif

  fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .jmp_req(jmp_req), .jmp_target(jmp_target),
    .br_taken(br_taken), .br_target(br_target),
    .ld_use(ld_use), .mc_start(mc_start), .mc_cycles(mc_cycles),
    .stall(stall), .stall_pm(stall_pm), .pc_mux_sel(pc_mux_sel),
    .jmp_loc(jmp_loc), .flush_id(flush_id), .bubble_ex(bubble_ex),
    .busy(busy),
`ifdef FETCH_PERF_CNT_EN
    .stall_cnt(stall_cnt), .redir_cnt(redir_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard
  logic [OUT_W-1:0] exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  string phase    = "init";

  // model state: 0 RUN, 1 HOLD, 2 FLUSH; m_left = hold cycles remaining
  int       m_mode = 0;
  int       m_left = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s: got %h expected %h", phase, tag, got, exp);
  endtask

  // One clock cycle: drive, predict, sample at negedge, compare, advance model.
  task automatic run_cycle(input logic rst_i, input logic br, input logic jmp,
                           input logic ld, input logic mc, input logic [3:0] n,
                           input logic [7:0] bt, input logic [7:0] jt);
    logic e_st, e_pc, e_fl, e_bx, e_busy;
    logic [7:0] e_loc;
    logic [OUT_W-1:0] exp_v, got_v;
    int nxt, nleft, prev_mode;
    @(posedge clk); #1;
    reset = rst_i; br_taken = br; jmp_req = jmp; ld_use = ld;
    mc_start = mc; mc_cycles = n; br_target = bt; jmp_target = jt;
    e_st = 0; e_pc = 0; e_fl = 0; e_bx = 0; e_busy = 0; e_loc = 8'h00;
    nxt = m_mode; nleft = m_left;
    if (rst_i) begin
      e_busy = (m_mode != 0);
      if (m_mode == 0) begin
        if (br) begin e_pc = 1; e_loc = bt; e_fl = 1; nxt = 2; end
        else if (jmp) begin e_pc = 1; e_loc = jt; nxt = 2; end
        else if (ld) begin e_st = 1; e_bx = 1; end
        else if (mc && n != 0) begin
          e_st = 1;
          if (n > 1) begin nxt = 1; nleft = int'(n) - 1; end
        end
      end else if (m_mode == 1) begin
        e_st = 1;
        nleft = m_left - 1;
        if (nleft == 0) nxt = 0;
      end else begin
        e_fl = 1;
        if (br) begin e_pc = 1; e_loc = bt; nxt = 2; end
        else nxt = 0;
      end
    end
    exp_q.push_back({e_st, e_st, e_pc, e_loc, e_fl, e_bx, e_busy});
    @(negedge clk);
    got_v = {stall, stall_pm, pc_mux_sel, jmp_loc, flush_id, bubble_ex, busy};
    exp_v = exp_q.pop_front();
    check("outs", 32'(got_v), 32'(exp_v));
    prev_mode = m_mode;
    check("state", 32'(state_dbg), 32'(prev_mode));
`ifdef FETCH_PERF_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
    check("redir_cnt", 32'(redir_cnt), 32'(m_redir_cnt));
    if (!rst_i) begin m_stall_cnt = 0; m_redir_cnt = 0; end
    else begin
      if (e_st && m_stall_cnt != 16'hFFFF) m_stall_cnt = m_stall_cnt + 1;
      if (e_pc && m_redir_cnt != 16'hFFFF) m_redir_cnt = m_redir_cnt + 1;
    end
`endif
    if (!rst_i) begin m_mode = 0; m_left = 0; end
    else begin m_mode = nxt; m_left = nleft; end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) run_cycle(1, 0, 0, 0, 0, 4'd0, 8'h00, 8'h00);
  endtask

  initial begin
    reset = 0; br_taken = 0; jmp_req = 0; ld_use = 0; mc_start = 0;
    mc_cycles = 0; br_target = 0; jmp_target = 0;
`ifdef FETCH_PERF_CNT_EN
    m_stall_cnt = 0; m_redir_cnt = 0;
`endif

    phase = "reset";
    run_cycle(0, 1, 0, 0, 0, 4'd0, 8'hAA, 8'h00);
    run_cycle(0, 1, 0, 0, 0, 4'd0, 8'hAA, 8'h00);
    idle(2);

    phase = "jump";
    run_cycle(1, 0, 1, 0, 0, 4'd0, 8'h00, 8'h3C);
    idle(2);

    phase = "br_prio";
    run_cycle(1, 1, 1, 1, 1, 4'd3, 8'h10, 8'h77);
    idle(2);

    phase = "br_in_flush";
    run_cycle(1, 1, 0, 0, 0, 4'd0, 8'h21, 8'h00);
    run_cycle(1, 1, 1, 1, 1, 4'd5, 8'h42, 8'h55);
    run_cycle(1, 0, 1, 1, 1, 4'd5, 8'h00, 8'h55);
    idle(1);

    phase = "ld_use";
    run_cycle(1, 0, 0, 1, 1, 4'd7, 8'h00, 8'h00);
    idle(1);

    phase = "mc4";
    run_cycle(1, 0, 0, 0, 1, 4'd4, 8'h00, 8'h00);
    run_cycle(1, 0, 0, 1, 1, 4'd4, 8'h00, 8'h00);
    run_cycle(1, 0, 0, 0, 1, 4'd4, 8'h00, 8'h00);
    run_cycle(1, 0, 0, 0, 1, 4'd4, 8'h00, 8'h00);
    idle(2);

    phase = "mc6_reset";
    run_cycle(1, 0, 0, 0, 1, 4'd6, 8'h00, 8'h00);
    run_cycle(1, 1, 0, 0, 1, 4'd6, 8'h33, 8'h00);
    run_cycle(0, 0, 0, 0, 1, 4'd6, 8'h00, 8'h00);
    idle(3);

    phase = "mc0_mc1";
    run_cycle(1, 0, 0, 0, 1, 4'd0, 8'h00, 8'h00);
    run_cycle(1, 0, 0, 0, 1, 4'd1, 8'h00, 8'h00);
    idle(1);

    phase = "mc15";
    run_cycle(1, 0, 0, 0, 1, 4'd15, 8'h00, 8'h00);
    idle(16);

    phase = "flush_reset";
    run_cycle(1, 0, 1, 0, 0, 4'd0, 8'h00, 8'h9E);
    run_cycle(0, 1, 0, 0, 0, 4'd0, 8'h12, 8'h00);
    idle(2);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom_range(0, 19) != 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)));
    end
    idle(20);

`ifdef FETCH_PERF_CNT_EN
    phase = "perf";
    run_cycle(0, 0, 0, 0, 0, 4'd0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1, 0, 0, 1, 0, 4'd0, 8'h00, 8'h00);
      idle(1);
    end
    for (int i = 0; i < 2; i++) begin
      run_cycle(1, 0, 1, 0, 0, 4'd0, 8'h00, 8'(8'h40 + i));
      idle(1);
    end
    idle(1);
    check("stall_cnt_3", 32'(stall_cnt), 32'd3);
    check("redir_cnt_2", 32'(redir_cnt), 32'd2);

    phase = "perf_sat";
    for (int i = 0; i < 4370; i++) begin
      run_cycle(1, 0, 0, 0, 1, 4'd15, 8'h00, 8'h00);
      idle(14);
    end
    idle(1);
    check("stall_cnt_sat", 32'(stall_cnt), 32'h0000FFFF);
`endif

    if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
